// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard.
// Two combinational read ports (S/T) and one write port (D). An optional bypass
// lets a read see this cycle's write data. Register 0 is hardwired to zero and
// can never be reserved.
module regfile_sb #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          D_En,
    input  logic [AW-1:0] D_Addr,
    input  logic [DW-1:0] D,
    input  logic          R_En,
    input  logic [AW-1:0] R_Addr,
    input  logic [AW-1:0] S_Addr,
    input  logic [AW-1:0] T_Addr,
    output logic [DW-1:0] S,
    output logic [DW-1:0] T,
    output logic          S_Busy,
    output logic          T_Busy,
    output logic [AW:0]   Busy_Cnt
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic wr_en, rsv_en, cnt_inc, cnt_dec;

    // Effective write/reserve strobes; held off while in reset so the bypass
    // path cannot leak write data onto the read ports during reset.
    assign wr_en  = reset_n && D_En && (D_Addr != '0);
    assign rsv_en = reset_n && R_En && (R_Addr != '0);

    // Next-state for data, busy bits and busy counter.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[D_Addr] = D;
            busy_d[D_Addr] = 1'b0;
        end
        // Reservation applied after the clear so it wins on a same-address hit.
        if (rsv_en) begin
            busy_d[R_Addr] = 1'b1;
        end
        cnt_inc = rsv_en && !busy_q[R_Addr];
        cnt_dec = wr_en && busy_q[D_Addr] && !(rsv_en && (R_Addr == D_Addr));
        cnt_d   = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // S read port: zero register, optional bypass, else stored state.
    always_comb begin
        S      = regs_q[S_Addr];
        S_Busy = busy_q[S_Addr];
        if (S_Addr == '0) begin
            S      = '0;
            S_Busy = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (S_Addr == D_Addr)) begin
            S      = D;
            S_Busy = rsv_en && (R_Addr == D_Addr);
        end
    end

    // T read port: same rules as S.
    always_comb begin
        T      = regs_q[T_Addr];
        T_Busy = busy_q[T_Addr];
        if (T_Addr == '0) begin
            T      = '0;
            T_Busy = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (T_Addr == D_Addr)) begin
            T      = D;
            T_Busy = rsv_en && (R_Addr == D_Addr);
        end
    end

    assign Busy_Cnt = cnt_q;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, SHALL set the data width of every register and data port.
REQ-002 Parameter AW, default 5, SHALL set the address width; register count NREG = 2**AW.
REQ-003 Parameter BYPASS, default 1, SHALL select write-to-read forwarding on the S/T ports (1 = on, 0 = off).
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 D_En  in  1  SHALL be the write enable for the current cycle.
REQ-007 D_Addr  in  AW  SHALL be the write destination.
REQ-008 D  in  DW  SHALL be the write data.
REQ-009 R_En  in  1  SHALL request reservation (busy-mark) of R_Addr.
REQ-010 R_Addr  in  AW  SHALL be the register to reserve.
REQ-011 S_Addr, T_Addr  in  AW each  SHALL be the asynchronous read addresses.
REQ-012 S, T  out  DW each  SHALL be the read data for S_Addr and T_Addr.
REQ-013 S_Busy, T_Busy  out  1 each  SHALL flag that the addressed register has a reservation outstanding.
REQ-014 Busy_Cnt  out  AW+1  SHALL give the number of registers currently reserved.

Function
REQ-015 Reads SHALL be combinational; S = contents of S_Addr, T = contents of T_Addr, no clock latency.
REQ-016 Register 0 SHALL read as 0 at all times; writes and reservations to address 0 SHALL be ignored, and S_Busy/T_Busy SHALL be 0 for address 0.
REQ-017 A write SHALL occur on the rising clk edge iff D_En=1 and D_Addr!=0; the written value SHALL be visible on reads from the following cycle.
REQ-018 With BYPASS=1, if D_En=1, D_Addr!=0 and S_Addr (T_Addr) equals D_Addr, S (T) SHALL equal D in the same cycle; with BYPASS=0 the stored value SHALL be returned.
REQ-019 Scoreboard: one busy bit per register; R_En=1 with R_Addr!=0 SHALL set busy[R_Addr] at the clock edge.
REQ-020 A write with D_En=1 SHALL clear busy[D_Addr] at the clock edge.
REQ-021 Simultaneous reserve and write to the same nonzero address SHALL leave the register written AND busy set (reservation wins).
REQ-022 Reserving an already-busy register SHALL leave it busy with no count change; writing a non-busy register SHALL not change the count.
REQ-023 Busy_Cnt SHALL be a registered counter updated each edge by (+1 if a new bit is set) (-1 if a set bit is cleared), net 0 when both hit different registers; it SHALL equal the population count of busy bits at all times and never wrap (range 0..NREG-1).
REQ-024 With BYPASS=1, S_Busy (T_Busy) SHALL read 0 in a cycle where an enabled write to that address is bypassed, unless R_En reserves the same address in that cycle.
REQ-025 No other internal state SHALL exist; all address values 0..NREG-1 SHALL be legal.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all NREG registers to 0, all busy bits to 0, and Busy_Cnt to 0, regardless of clk.
REQ-027 While reset_n=0, D_En and R_En SHALL have no effect; the first write SHALL occur on the first rising edge after reset_n rises.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding reservations and data immediately.

Verification
REQ-029 Reset then read all addresses -> S=T=0, S_Busy=T_Busy=0, Busy_Cnt=0.
REQ-030 Write D=32'hDEADBEEF to addr 5, next cycle S_Addr=5 -> S=32'hDEADBEEF; write to addr 0 -> S_Addr=0 reads 0.
REQ-031 BYPASS=1: D_En=1, D_Addr=7, D=32'h1234, S_Addr=7 same cycle -> S=32'h1234; BYPASS=0 -> S=old value.
REQ-032 Reserve 3, 4, 3 on consecutive edges -> Busy_Cnt 1,2,2, S_Busy=1 for addr 3; write addr 3 -> Busy_Cnt=1, S_Busy=0.
REQ-033 Same edge R_En/R_Addr=9 and D_En/D_Addr=9, D=32'hA5 -> reg9=32'hA5, busy[9]=1; same edge reserve 10 and write busy 4 -> Busy_Cnt unchanged.
REQ-034 Reserve 31 registers, assert reset_n=0 between clock edges -> all outputs 0 immediately, Busy_Cnt=0.
